// File: rtl/rv_dmem_arbiter_if.sv
// Bus bundle between the two requesters (core, host), the arbiter and data memory.
// Ports (all carried in the bundle):
//   c_*  core request / grant / load return
//   h_*  host request / grant / load return
//   m_*  request to memory and memory load return
// Modports: slave = arbiter view, master = requester/memory side view.
interface rv_dmem_arbiter_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;

    logic [ADDR_W-1:0] c_addr_i;
    logic [DATA_W-1:0] c_data_s_i;
    logic [SEL_W-1:0]  c_select_i;
    logic              c_load_i;
    logic              c_store_i;
    logic              c_ready_o;
    logic [DATA_W-1:0] c_data_l_o;
    logic              c_load_done_o;

    logic [ADDR_W-1:0] h_addr_i;
    logic [DATA_W-1:0] h_data_s_i;
    logic [SEL_W-1:0]  h_select_i;
    logic              h_load_i;
    logic              h_store_i;
    logic              h_ready_o;
    logic [DATA_W-1:0] h_data_l_o;
    logic              h_load_done_o;

    logic [ADDR_W-1:0] m_addr_o;
    logic [DATA_W-1:0] m_data_s_o;
    logic [SEL_W-1:0]  m_select_o;
    logic              m_load_o;
    logic              m_store_o;
    logic              m_ready_i;
    logic [DATA_W-1:0] m_data_l_i;
    logic              m_load_done_i;

    modport slave (
        input  c_addr_i, c_data_s_i, c_select_i, c_load_i, c_store_i,
        output c_ready_o, c_data_l_o, c_load_done_o,
        input  h_addr_i, h_data_s_i, h_select_i, h_load_i, h_store_i,
        output h_ready_o, h_data_l_o, h_load_done_o,
        output m_addr_o, m_data_s_o, m_select_o, m_load_o, m_store_o,
        input  m_ready_i, m_data_l_i, m_load_done_i
    );

    modport master (
        output c_addr_i, c_data_s_i, c_select_i, c_load_i, c_store_i,
        input  c_ready_o, c_data_l_o, c_load_done_o,
        output h_addr_i, h_data_s_i, h_select_i, h_load_i, h_store_i,
        input  h_ready_o, h_data_l_o, h_load_done_o,
        input  m_addr_o, m_data_s_o, m_select_o, m_load_o, m_store_o,
        output m_ready_i, m_data_l_i, m_load_done_i
    );
endinterface

// File: rtl/rv_dmem_arbiter.sv
// Shares the single data-memory port between the core load/store unit and a
// host/debug master. One grant per cycle, one outstanding load whose data is
// routed back to its issuer; a starvation counter forces host progress.
// Ports:
//   clk_i    clock, rising edge
//   rst_n_i  synchronous active-low reset
//   bus      rv_dmem_arbiter_if.slave (core, host and memory sides)
module rv_dmem_arbiter #(
    parameter int unsigned G_HOST_STARVE_LIMIT = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    rv_dmem_arbiter_if.slave         bus
);
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(G_HOST_STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, C_WAIT, H_WAIT} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;

    logic c_req, h_req, h_sel, c_sel, open;
    logic grant_c, grant_h;

    // Request decode and selection
    always_comb begin
        c_req   = bus.c_load_i | bus.c_store_i;
        h_req   = bus.h_load_i | bus.h_store_i;
        h_sel   = h_req && (!c_req || starve_q == LIMIT);
        c_sel   = c_req && !h_sel;
        // A completing load frees the port in the same cycle.
        open    = (state_q == IDLE) || bus.m_load_done_i;
        grant_c = rst_n_i && open && c_sel && bus.m_ready_i;
        grant_h = rst_n_i && open && h_sel && bus.m_ready_i;
    end

    // Memory request mux, grants and load return
    always_comb begin
        bus.m_addr_o   = bus.c_addr_i;
        bus.m_data_s_o = bus.c_data_s_i;
        bus.m_select_o = bus.c_select_i;
        bus.m_load_o   = 1'b0;
        bus.m_store_o  = 1'b0;
        if (h_sel) begin
            bus.m_addr_o   = bus.h_addr_i;
            bus.m_data_s_o = bus.h_data_s_i;
            bus.m_select_o = bus.h_select_i;
            bus.m_load_o   = rst_n_i && open && bus.h_load_i;
            bus.m_store_o  = rst_n_i && open && bus.h_store_i;
        end else if (c_sel) begin
            bus.m_load_o   = rst_n_i && open && bus.c_load_i;
            bus.m_store_o  = rst_n_i && open && bus.c_store_i;
        end
        bus.c_ready_o     = grant_c;
        bus.h_ready_o     = grant_h;
        bus.c_data_l_o    = bus.m_data_l_i;
        bus.h_data_l_o    = bus.m_data_l_i;
        // Done in IDLE is spurious and dropped by the state qualifier.
        bus.c_load_done_o = rst_n_i && bus.m_load_done_i && (state_q == C_WAIT);
        bus.h_load_done_o = rst_n_i && bus.m_load_done_i && (state_q == H_WAIT);
    end

    // Next state and starvation counter
    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        if (grant_c && bus.c_load_i) begin
            state_d = C_WAIT;
        end else if (grant_h && bus.h_load_i) begin
            state_d = H_WAIT;
        end else if (bus.m_load_done_i) begin
            state_d = IDLE;
        end
        if (!h_req || grant_h) begin
            starve_d = '0;
        end else if (grant_c && starve_q < LIMIT) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end
endmodule

// File: tb/tb_rv_dmem_arbiter.sv
// Directed bench for rv_dmem_arbiter: inputs driven after the falling edge,
// outputs sampled 1 ns later, state advances on the rising edge.
module tb_rv_dmem_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    rv_dmem_arbiter_if bus ();

    rv_dmem_arbiter #(.G_HOST_STARVE_LIMIT(4)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(negedge clk);
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.c_addr_i      = 32'h0;
        bus.c_data_s_i    = 32'h0;
        bus.c_select_i    = 4'hf;
        bus.c_load_i      = 1'b0;
        bus.c_store_i     = 1'b0;
        bus.h_addr_i      = 32'h0;
        bus.h_data_s_i    = 32'h0;
        bus.h_select_i    = 4'hf;
        bus.h_load_i      = 1'b0;
        bus.h_store_i     = 1'b0;
        bus.m_ready_i     = 1'b1;
        bus.m_data_l_i    = 32'h0;
        bus.m_load_done_i = 1'b0;

        // Reset: outputs forced low even with requests and done present
        drive_edge();
        bus.c_load_i = 1'b1; bus.h_store_i = 1'b1; bus.m_load_done_i = 1'b1;
        #1;
        check("rst_m_load",  32'(bus.m_load_o), 32'd0);
        check("rst_m_store", 32'(bus.m_store_o), 32'd0);
        check("rst_c_ready", 32'(bus.c_ready_o), 32'd0);
        check("rst_h_ready", 32'(bus.h_ready_o), 32'd0);
        check("rst_c_done",  32'(bus.c_load_done_o), 32'd0);
        @(posedge clk); #1;
        check("rst_state", 32'(dut.state_q), 32'd0);
        check("rst_cnt",   32'(dut.starve_q), 32'd0);
        drive_edge();
        bus.c_load_i = 1'b0; bus.h_store_i = 1'b0; bus.m_load_done_i = 1'b0;
        rst_n = 1'b1;

        // Core-only load, data two cycles after grant
        drive_edge();
        bus.c_load_i = 1'b1; bus.c_addr_i = 32'h100;
        #1;
        check("cl_ready", 32'(bus.c_ready_o), 32'd1);
        check("cl_m_load", 32'(bus.m_load_o), 32'd1);
        check("cl_addr", bus.m_addr_o, 32'h100);
        drive_edge();
        bus.c_load_i = 1'b0;
        #1;
        check("cl_nodone1", 32'(bus.c_load_done_o), 32'd0);
        drive_edge();
        bus.m_load_done_i = 1'b1; bus.m_data_l_i = 32'hdeadbeef;
        #1;
        check("cl_done", 32'(bus.c_load_done_o), 32'd1);
        check("cl_data", bus.c_data_l_o, 32'hdeadbeef);
        check("cl_h_done", 32'(bus.h_load_done_o), 32'd0);
        drive_edge();
        bus.m_load_done_i = 1'b0;
        #1;
        check("cl_done_once", 32'(bus.c_load_done_o), 32'd0);

        // Simultaneous stores: C,C,C,C,H repeating
        drive_edge();
        bus.c_store_i = 1'b1; bus.c_addr_i = 32'h200;
        bus.h_store_i = 1'b1; bus.h_addr_i = 32'h300;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("st_c_ready", 32'(bus.c_ready_o), (i % 5 == 4) ? 32'd0 : 32'd1);
            check("st_h_ready", 32'(bus.h_ready_o), (i % 5 == 4) ? 32'd1 : 32'd0);
            check("st_addr", bus.m_addr_o, (i % 5 == 4) ? 32'h300 : 32'h200);
            check("st_m_store", 32'(bus.m_store_o), 32'd1);
            drive_edge();
        end
        bus.c_store_i = 1'b0; bus.h_store_i = 1'b0;

        // Host load outstanding blocks a core store until done
        bus.h_load_i = 1'b1; bus.h_addr_i = 32'h400;
        #1;
        check("wb_h_ready", 32'(bus.h_ready_o), 32'd1);
        drive_edge();
        bus.h_load_i = 1'b0; bus.c_store_i = 1'b1; bus.c_addr_i = 32'h404;
        #1;
        check("wb_c_blk1", 32'(bus.c_ready_o), 32'd0);
        check("wb_m_store_blk", 32'(bus.m_store_o), 32'd0);
        drive_edge();
        #1;
        check("wb_c_blk2", 32'(bus.c_ready_o), 32'd0);
        drive_edge();
        bus.m_load_done_i = 1'b1; bus.m_data_l_i = 32'h12345678;
        #1;
        check("wb_h_done", 32'(bus.h_load_done_o), 32'd1);
        check("wb_h_data", bus.h_data_l_o, 32'h12345678);
        check("wb_c_ready", 32'(bus.c_ready_o), 32'd1);
        check("wb_c_done", 32'(bus.c_load_done_o), 32'd0);
        drive_edge();
        bus.m_load_done_i = 1'b0; bus.c_store_i = 1'b0;
        #1;
        check("wb_idle_state", 32'(dut.state_q), 32'd0);

        // Backpressure with counter at 2 (host store waiting)
        bus.c_store_i = 1'b1; bus.h_store_i = 1'b1;
        bus.c_addr_i = 32'h500; bus.h_addr_i = 32'h600;
        drive_edge();
        drive_edge();
        #1;
        check("bp_cnt_pre", 32'(dut.starve_q), 32'd2);
        bus.c_store_i = 1'b0; bus.c_load_i = 1'b1; bus.m_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_m_load", 32'(bus.m_load_o), 32'd1);
            check("bp_c_ready", 32'(bus.c_ready_o), 32'd0);
            check("bp_h_ready", 32'(bus.h_ready_o), 32'd0);
            drive_edge();
            #1;
            check("bp_cnt", 32'(dut.starve_q), 32'd2);
        end
        bus.m_ready_i = 1'b1;
        #1;
        check("bp_grant", 32'(bus.c_ready_o), 32'd1);
        drive_edge();
        #1;
        check("bp_cnt_inc", 32'(dut.starve_q), 32'd3);
        check("bp_state", 32'(dut.state_q), 32'd1);

        // Back-to-back: host load issues in the core's done cycle
        bus.c_load_i = 1'b0; bus.h_store_i = 1'b0; bus.h_load_i = 1'b1;
        bus.h_addr_i = 32'h700; bus.m_load_done_i = 1'b1; bus.m_data_l_i = 32'h0badf00d;
        #1;
        check("bb_c_done", 32'(bus.c_load_done_o), 32'd1);
        check("bb_h_done_old", 32'(bus.h_load_done_o), 32'd0);
        check("bb_h_ready", 32'(bus.h_ready_o), 32'd1);
        drive_edge();
        bus.h_load_i = 1'b0; bus.m_load_done_i = 1'b0;
        #1;
        check("bb_state", 32'(dut.state_q), 32'd2);
        drive_edge();
        bus.m_load_done_i = 1'b1; bus.m_data_l_i = 32'hcafe0001;
        #1;
        check("bb_h_done", 32'(bus.h_load_done_o), 32'd1);
        check("bb_h_data", bus.h_data_l_o, 32'hcafe0001);
        drive_edge();
        bus.m_load_done_i = 1'b0;

        // Reset mid-load abandons it; later done is ignored
        bus.c_load_i = 1'b1; bus.c_addr_i = 32'h800;
        drive_edge();
        bus.c_load_i = 1'b0; rst_n = 1'b0;
        drive_edge();
        rst_n = 1'b1;
        drive_edge();
        bus.m_load_done_i = 1'b1;
        #1;
        check("rm_c_done", 32'(bus.c_load_done_o), 32'd0);
        check("rm_h_done", 32'(bus.h_load_done_o), 32'd0);
        check("rm_state", 32'(dut.state_q), 32'd0);

        // Spurious done in IDLE with no requests
        drive_edge();
        #1;
        check("sp_c_done", 32'(bus.c_load_done_o), 32'd0);
        check("sp_h_done", 32'(bus.h_load_done_o), 32'd0);
        check("sp_c_ready", 32'(bus.c_ready_o), 32'd0);
        check("sp_h_ready", 32'(bus.h_ready_o), 32'd0);
        check("sp_m_load", 32'(bus.m_load_o), 32'd0);
        drive_edge();
        bus.m_load_done_i = 1'b0;
        #1;
        check("sp_state", 32'(dut.state_q), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
